hidden_activation: RTL and testbench
====================================

# hidden_activation

Sequential activation stage directly downstream of the hidden-layer neuron. It accepts one 10-bit signed pre-activation sum per transaction and returns f(X) = 0.5·[X/(1+|X|)+1] as a 10-bit unsigned fraction. The division is done with an iterative restoring divider, one quotient bit per cycle. Valid/ready handshakes on both sides let it sit between the neuron array and the output layer.

## Interface
- IN_W, 10: width of the signed pre-activation input (two's complement).
- FRAC_W, 5: fractional bits of the input, so the real value is X = in_data / 2^FRAC_W (Q4.5 at defaults).
- OUT_W, 10: width of the unsigned output fraction, so the real value is y = out_data / 2^OUT_W.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a pre-activation value.
- in_ready  output  1  block can accept input; high only in IDLE.
- in_data  input  IN_W  signed pre-activation sum from the hidden neuron.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  activation result.

## Operation
- Arithmetic, with integer codes:
  - A = |in_data|, held in IN_W bits unsigned, so -2^(IN_W-1) maps to 2^(IN_W-1).
  - D = 2^FRAC_W + A, held in IN_W+1 bits.
  - Q = floor(A · 2^(OUT_W-1) / D). Because A < D, Q < 2^(OUT_W-1).
  - out_data = 2^(OUT_W-1) + Q when in_data ≥ 0, and 2^(OUT_W-1) − Q when in_data < 0. This truncates r toward zero.
- Restoring division runs for OUT_W-1 iterations and uses no multiplier or divider operator.
  - Initial state: rem = A, q = 0.
  - Each iteration: rem = rem<<1. If rem ≥ D, then rem -= D and the next quotient bit is 1, else 0. Bits are produced MSB first.
- FSM states: IDLE, DIV, DONE.
  - IDLE: in_ready=1. When in_valid is high, latch sign, A and D, set rem=A and cnt=0, and go to DIV.
  - DIV: perform one iteration per cycle and increment cnt. After iteration OUT_W-2 completes, form out_data, set out_valid=1 and go to DONE.
  - DONE: hold out_data and out_valid stable. When out_ready is high, clear out_valid and go to IDLE.
- No input is accepted in DIV or DONE; in_valid is ignored there.
- There is no same-cycle accept on the cycle a DONE handshake completes; the next accept happens in IDLE.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, rem=0, q=0, cnt=0. in_ready=1 as soon as reset is released.
- in_ready is a combinational decode of state (IDLE). All other outputs are registered.
- Latency: out_valid rises OUT_W-1 cycles after the accepting edge. At defaults that is 9 cycles.
- Throughput: one result per OUT_W+1 cycles with out_ready held high (accept, 9 DIV cycles, 1 DONE cycle).
- Backpressure: DONE may last any number of cycles. out_data must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-DIV or mid-DONE: the transaction is aborted. Outputs take reset values immediately and no result is emitted.
- Boundary inputs:
  - in_data=0 gives 2^(OUT_W-1).
  - The most negative code must not overflow A or D.

## Structure
- Shared package nn_pkg holds:
  - the IN_W, FRAC_W and OUT_W defaults, shared with the hidden neuron;
  - typedef act_state_t {IDLE, DIV, DONE}.
- One sub-module fits naturally: act_div_step, a combinational single-iteration restoring step. Inputs are rem and D; outputs are the next rem and the quotient bit. The FSM, counter and handshake registers stay in hidden_activation.

## Test plan
- Reset, then in_data=0 → out_data=512 exactly 9 cycles after the accept edge; in_ready low until the DONE handshake.
- in_data=32 (1.0) → 768; in_data=−32 → 256; in_data=16 (0.5) → 682.
- Extremes: in_data=511 → 993; in_data=−512 → 31. No overflow or X values on any signal.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid rises. out_data stays stable and in_ready stays 0.
  - Keep in_valid high with a new value throughout; it is not accepted until IDLE returns.
- Back-to-back with out_ready=1 and in_valid=1 continuously, inputs 32, −32, 0 → outputs 768, 256, 512, one accept every 11 cycles.
- Assert reset at cycle 4 of DIV → out_valid=0 and in_ready=1 after release. The next input, 16, yields 682 with no trace of the aborted transaction.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: widths shared by the hidden neuron and its activation stage, plus the activation FSM states.
package nn_pkg;
    localparam int NN_IN_W   = 10;
    localparam int NN_FRAC_W = 5;
    localparam int NN_OUT_W  = 10;
    typedef enum logic [1:0] {IDLE, DIV, DONE} act_state_t;
endpackage

// File: rtl/act_div_step.sv
// act_div_step: one combinational restoring-division iteration (shift, compare, conditional subtract).
module act_div_step #(
    parameter int W = 11
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] remNext,
    output logic         qBit
);
    logic [W:0] shifted;
    logic [W:0] diff;
    assign shifted = {rem, 1'b0};
    assign diff    = shifted - {1'b0, divisor};
    assign qBit    = shifted >= {1'b0, divisor};
    // rem < divisor on entry, so whichever branch is taken fits back into W bits
    assign remNext = qBit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/hidden_activation.sv
// hidden_activation: y = 0.5*(X/(1+|X|)+1) via a bit-serial restoring divider with valid/ready on both sides.
module hidden_activation
    import nn_pkg::*;
#(
    parameter int IN_W   = NN_IN_W,
    parameter int FRAC_W = NN_FRAC_W,
    parameter int OUT_W  = NN_OUT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data
);
    localparam int DW = IN_W + 1;
    localparam int QW = OUT_W - 1;
    localparam int CW = $clog2(QW);
    localparam logic [DW-1:0]    DBIAS = DW'(1) << FRAC_W;
    localparam logic [OUT_W-1:0] HALF  = {1'b1, {QW{1'b0}}};

    act_state_t    state;
    logic          neg;
    logic [DW-1:0] divisor;
    logic [DW-1:0] rem;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;
    logic [IN_W-1:0] absIn;
    logic [DW-1:0] remNext;
    logic          qBit;
    logic [QW-1:0] qNext;
    logic [OUT_W-1:0] result;

    // Unsigned magnitude: the most negative code lands on 2^(IN_W-1) without overflow
    assign absIn    = in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;
    assign in_ready = state == IDLE;
    assign qNext    = {q[QW-2:0], qBit};
    assign result   = neg ? HALF - {1'b0, qNext} : HALF + {1'b0, qNext};

    act_div_step #(.W(DW)) step (
        .rem     (rem),
        .divisor (divisor),
        .remNext (remNext),
        .qBit    (qBit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            neg       <= 1'b0;
            divisor   <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                neg     <= in_data[IN_W-1];
                divisor <= {1'b0, absIn} + DBIAS;
                rem     <= {1'b0, absIn};
                q       <= '0;
                cnt     <= '0;
                state   <= DIV;
            end
        end else if (state == DIV) begin
            rem <= remNext;
            q   <= qNext;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(QW - 1)) begin
                out_data  <= result;
                out_valid <= 1'b1;
                state     <= DONE;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_hidden_activation.sv
// tb_hidden_activation: randomized and directed checks of hidden_activation against an arithmetic model.
module tb_hidden_activation;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic signed [9:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [9:0]        out_data;
    int nChecks = 0;
    int nPass = 0;
    int cycle = 0;

    hidden_activation dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int refAct(input int x);
        int a = x < 0 ? -x : x;
        int q = (a * 512) / (32 + a);
        return x < 0 ? 512 - q : 512 + q;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic waitResult(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 40);
        if (!out_valid) check("timeout", 0, 1);
    endtask

    task automatic transact(input int x, input int bp);
        int n;
        int held;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 10'(x);
        out_ready = 1'b0;
        check("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1 in_data = 10'($urandom);
        waitResult(n);
        check("latency", n, 9);
        check("result", int'(out_data), refAct(x));
        check("in_ready_done", int'(in_ready), 0);
        held = int'(out_data);
        repeat (bp) begin
            @(negedge clk);
            in_data = 10'($urandom);
            check("hold_data", int'(out_data), held);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("valid_clear", int'(out_valid), 0);
        check("in_ready_back", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int vals[3] = '{32, -32, 0};
        int acc[3];
        int n;
        int k;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        transact(0, 0);
        transact(32, 0);
        transact(-32, 0);
        transact(16, 0);
        transact(511, 1);
        transact(-512, 1);
        transact(99, 5);

        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            k = 0;
            while (!in_ready && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("b2b_ready", int'(in_ready), 1);
            in_data = 10'(vals[i]);
            @(posedge clk);
            #1 acc[i] = cycle;
            waitResult(n);
            check("b2b_latency", n, 9);
            check("b2b_result", int'(out_data), refAct(vals[i]));
            if (i == 2) in_valid = 1'b0;
        end
        check("b2b_gap1", acc[1] - acc[0], 11);
        check("b2b_gap2", acc[2] - acc[1], 11);
        @(negedge clk);
        out_ready = 1'b0;

        @(negedge clk);
        in_valid = 1'b1;
        in_data = 10'(100);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_data", int'(out_data), 0);
        check("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_valid", int'(out_valid), 0);
            check("post_abort_ready", int'(in_ready), 1);
        end
        transact(16, 2);

        repeat (20) transact(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
